decode_multi_fetch: RTL

Parametrised clocked decode/operand-fetch stage between the instruction issuer and execute. It requests one instruction word from the issuer and decodes its register fields. It then reads up to NUM_RD operands serially from the register bank and presents them with a type code to the consumer. All three interfaces use two-phase toggle handshakes (an event is a level change on the trigger/ready line).

---
 rtl/decode_multi_fetch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_multi_fetch.sv
// rtl/decode_multi_fetch.sv - decode and serial operand-fetch stage with toggle handshakes
module decode_multi_fetch #(
  parameter int DATA_W    = 32,
  parameter int NUM_RD    = 4,
  parameter int RB_ADDR_W = 32,
  parameter int TIMEOUT   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     triggerIn,
  output logic                     readyOut,
  output logic [NUM_RD*DATA_W-1:0] dataOut,
  output logic [3:0]               typeOut,
  output logic                     errOut,
  output logic                     triggerOut,
  input  logic                     readyIn,
  input  logic [DATA_W-1:0]        dataIn,
  output logic                     triggerOutRB,
  output logic [RB_ADDR_W-1:0]     addrRB,
  input  logic                     readyInRB,
  input  logic [DATA_W-1:0]        dataInRB
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_I,
    S_DECODE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DONE
  } state_t;

  // Slots beyond NUM_RD are never requested.
  localparam logic [3:0] SLOT_KEEP = 4'((5'd1 << NUM_RD) - 5'd1);

  state_t                   state;
  state_t                   state_nxt;
  logic                     trig_seen;
  logic                     rdy_seen;
  logic                     rbrdy_seen;
  logic [DATA_W-1:0]        instr;
  logic [31:0]              iw;
  logic                     unused_iw;
  logic [3:0]               dec_mask;
  logic [3:0]               dec_type;
  logic [3:0]               mask;
  logic [3:0]               type_q;
  logic [1:0]               cur_slot;
  logic [1:0]               issue_slot;
  logic [3:0]               issue_field;
  logic [3:0][DATA_W-1:0]   slots;
  logic [31:0]              wait_cnt;
  logic                     trig_evt;
  logic                     rdy_evt;
  logic                     rb_evt;
  logic                     wait_expired;
  logic                     do_accept;
  logic                     do_latch;
  logic                     do_decode;
  logic                     do_issue;
  logic                     do_store;
  logic                     do_timeout;
  logic                     do_done;

  // Field decoding works on a 32-bit view of the instruction word.
  assign iw        = 32'(instr);
  assign unused_iw = ^{iw[24:20], iw[6:5]};

  assign trig_evt     = (triggerIn != trig_seen);
  assign rdy_evt      = (readyIn != rdy_seen);
  assign rb_evt       = (readyInRB != rbrdy_seen);
  assign wait_expired = (TIMEOUT > 0) && (wait_cnt == 32'(TIMEOUT - 1));

  // Instruction class and the operand slots it needs (slot order Rn, Rm, Rs, Rd).
  always_comb begin
    dec_mask = 4'b0000;
    case (iw[27:25])
      3'b000:  dec_mask = {1'b0, iw[4] & ~iw[7], 2'b11};
      3'b001:  dec_mask = 4'b0001;
      3'b010:  dec_mask = 4'b1001;
      3'b011:  dec_mask = 4'b1011;
      default: dec_mask = 4'b0000;
    endcase
    dec_mask = dec_mask & SLOT_KEEP;
    dec_type = (iw[31:28] == 4'hF) ? 4'hF : {1'b0, iw[27:25]};
  end

  // Lowest pending slot and the register index it reads.
  always_comb begin
    issue_slot = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) issue_slot = 2'(k);
    end
    case (issue_slot)
      2'd0:    issue_field = iw[19:16];
      2'd1:    issue_field = iw[3:0];
      2'd2:    issue_field = iw[11:8];
      default: issue_field = iw[15:12];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and per-cycle action strobes.
  always_comb begin
    state_nxt  = state;
    do_accept  = 1'b0;
    do_latch   = 1'b0;
    do_decode  = 1'b0;
    do_issue   = 1'b0;
    do_store   = 1'b0;
    do_timeout = 1'b0;
    do_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_evt) begin
          do_accept = 1'b1;
          state_nxt = S_REQ_I;
        end
      end
      S_REQ_I: begin
        if (rdy_evt) begin
          do_latch  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        do_decode = 1'b1;
        state_nxt = (dec_mask != 4'b0000) ? S_RD_ISSUE : S_DONE;
      end
      S_RD_ISSUE: begin
        if (mask != 4'b0000) begin
          do_issue  = 1'b1;
          state_nxt = S_RD_WAIT;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_RD_WAIT: begin
        if (rb_evt) begin
          do_store  = 1'b1;
          state_nxt = (mask != 4'b0000) ? S_RD_ISSUE : S_DONE;
        end else if (wait_expired) begin
          do_timeout = 1'b1;
          state_nxt  = (mask != 4'b0000) ? S_RD_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        do_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge trackers, handshake toggles, operand slots and published results.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_seen    <= triggerIn;
      rdy_seen     <= readyIn;
      rbrdy_seen   <= readyInRB;
      readyOut     <= 1'b0;
      dataOut      <= '0;
      typeOut      <= 4'h0;
      errOut       <= 1'b0;
      triggerOut   <= 1'b0;
      triggerOutRB <= 1'b0;
      addrRB       <= '0;
      instr        <= '0;
      mask         <= 4'b0000;
      type_q       <= 4'h0;
      cur_slot     <= 2'd0;
      slots        <= '0;
      wait_cnt     <= 32'd0;
    end else begin
      // Outside their awaited state these lines are simply absorbed.
      rdy_seen   <= readyIn;
      rbrdy_seen <= readyInRB;
      if (do_accept) begin
        trig_seen  <= triggerIn;
        triggerOut <= ~triggerOut;
      end
      if (do_latch) instr <= dataIn;
      if (do_decode) begin
        mask   <= dec_mask;
        type_q <= dec_type;
        slots  <= '0;
      end
      if (do_issue) begin
        cur_slot           <= issue_slot;
        addrRB             <= RB_ADDR_W'(issue_field);
        triggerOutRB       <= ~triggerOutRB;
        mask[issue_slot]   <= 1'b0;
        wait_cnt           <= 32'd0;
      end
      if (state == S_RD_WAIT && !rb_evt) wait_cnt <= wait_cnt + 32'd1;
      if (do_store) slots[cur_slot] <= dataInRB;
      if (do_timeout) errOut <= 1'b1;
      if (do_done) begin
        dataOut  <= slots[NUM_RD-1:0];
        typeOut  <= type_q;
        readyOut <= ~readyOut;
      end
    end
  end

endmodule
